imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 134 +++++++++++++
 tb/tb_imem_loader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: streams program bytes into instruction memory as big-endian
// 32-bit words while holding the processor in reset until the image is in.
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [7:0]  FILL       = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   byte_count
);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, END} state_t;

    state_t                state_q, state_d;
    logic [31:0]           asm_q, asm_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  ready;
    logic                  full;
    logic [1:0]            lane;
    logic [31:0]           word;
    logic [31:0]           padded;

    // Memory is exactly full once the count reaches 2^ADDR_WIDTH.
    assign full = cnt_q[ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            asm_q   <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            asm_q   <= asm_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        asm_d   = asm_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        err_d   = err_q;
        ready   = 1'b0;
        lane    = cnt_q[1:0];
        word    = asm_q;
        word[{~lane, 3'b000} +: 8] = in_data;
        // Lanes after the current byte are padded for a partial final word.
        padded  = word;
        for (int j = 1; j < 4; j++) begin
            if (j > int'(lane)) begin
                padded[8*(3-j) +: 8] = FILL;
            end
        end
        unique case (state_q)
            IDLE, END: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    asm_d   = '0;
                end
            end
            LOAD: begin
                ready = !full;
                if (in_valid && full) begin
                    err_d   = 1'b1;
                    state_d = END;
                end else if (in_valid) begin
                    asm_d  = word;
                    cnt_d  = cnt_q + 1'b1;
                    addr_d = {cnt_q[ADDR_WIDTH-1:2], 2'b00};
                    if (lane == 2'd3) begin
                        we_d    = 1'b1;
                        wdata_d = word;
                        if (in_last) begin
                            state_d = END;
                            done_d  = 1'b1;
                        end
                    end else if (in_last) begin
                        // The partial word's write strobe covers the FLUSH cycle.
                        we_d    = 1'b1;
                        wdata_d = padded;
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                state_d = END;
                done_d  = 1'b1;
            end
        endcase
    end

    assign in_ready   = ready;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign cpu_hold   = (state_q != END);
    assign done       = done_q;
    assign error      = err_q;
    assign byte_count = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven and randomized check of imem_loader against
// a byte-list reference model (16-byte memory).
module tb_imem_loader;

    localparam int         AW   = 4;
    localparam int         CAP  = 1 << AW;
    localparam logic [7:0] FILLB = 8'h00;

    logic          clk = 1'b0;
    logic          reset, start, in_valid, in_last;
    logic [7:0]    in_data;
    logic          in_ready, mem_we, cpu_hold, done, error;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   byte_count;

    imem_loader #(.ADDR_WIDTH(AW), .FILL(FILLB)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .done(done),
        .error(error), .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   addr;
        logic [31:0] data;
        int   cyc;
    } wr_t;

    typedef struct {
        int         n;
        logic [7:0] first;
        logic [7:0] step;
        bit         last;
        bit         gappy;
        int         exp_w;
        bit         exp_done;
        bit         exp_err;
        int         exp_cnt;
    } vec_t;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         stalls;
    wr_t        wr_q[$];
    logic [7:0] img[$];
    int         acc_cyc[0:31];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we === 1'b1)
            wr_q.push_back('{int'(mem_addr), mem_wdata, cyc});
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_ready", 64'(in_ready), 64'd1);
        check("start_hold", 64'(cpu_hold), 64'd1);
        check("start_done", 64'(done), 64'd0);
        check("start_err", 64'(error), 64'd0);
        check("start_cnt", 64'(byte_count), 64'd0);
    endtask

    task automatic drive(input int lo, input int hi, input bit last,
                         input bit gappy);
        bit refused = 1'b0;
        for (int i = lo; i <= hi && !refused; i++) begin
            if (gappy) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                in_last  = 1'($urandom);
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = img[i];
            in_last  = last && (i == hi);
            if (in_ready) acc_cyc[i] = cyc;
            else begin
                refused = 1'b1;
                stalls++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Reference: group accepted bytes into big-endian words at 4*w.
    task automatic verify(input string tag, input int n, input bit last,
                          input int exp_w, input bit exp_done,
                          input bit exp_err, input int exp_cnt);
        int acc = (n > CAP) ? CAP : n;
        bit ovf = (n > CAP);
        int nw  = (!ovf && last) ? (acc + 3) / 4 : acc / 4;
        repeat (4) @(negedge clk);
        check({tag, "_writes"}, 64'(wr_q.size()), 64'(exp_w));
        check({tag, "_model_w"}, 64'(wr_q.size()), 64'(nw));
        check({tag, "_stall"}, 64'(stalls), 64'(ovf));
        for (int w = 0; w < nw && w < wr_q.size(); w++) begin
            logic [31:0] d = '0;
            int li = (4*w + 3 < acc) ? 4*w + 3 : acc - 1;
            for (int l = 0; l < 4; l++)
                d = {d[23:0], (4*w + l < acc) ? img[4*w + l] : FILLB};
            check({tag, "_addr"}, 64'(wr_q[w].addr), 64'(4*w));
            check({tag, "_data"}, 64'(wr_q[w].data), 64'(d));
            check({tag, "_lat"}, 64'(wr_q[w].cyc), 64'(acc_cyc[li] + 1));
        end
        check({tag, "_done"}, 64'(done), 64'(exp_done));
        check({tag, "_err"}, 64'(error), 64'(exp_err));
        check({tag, "_cnt"}, 64'(byte_count), 64'(exp_cnt));
        check({tag, "_hold"}, 64'(cpu_hold), 64'(!(exp_done || exp_err)));
        check({tag, "_rdy"}, 64'(in_ready), 64'd0);
    endtask

    task automatic run_case(input string tag, input int n, input bit last,
                            input bit gappy, input int exp_w,
                            input bit exp_done, input bit exp_err,
                            input int exp_cnt);
        wr_q.delete();
        stalls = 0;
        do_start();
        drive(0, n - 1, last, gappy);
        verify(tag, n, last, exp_w, exp_done, exp_err, exp_cnt);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{4,  8'hFE, 8'h00, 1'b1, 1'b0, 1, 1'b1, 1'b0, 4};
        vecs[1] = '{8,  8'h00, 8'h01, 1'b1, 1'b0, 2, 1'b1, 1'b0, 8};
        vecs[2] = '{6,  8'h11, 8'h01, 1'b1, 1'b0, 2, 1'b1, 1'b0, 6};
        vecs[3] = '{17, 8'h20, 8'h01, 1'b0, 1'b0, 4, 1'b0, 1'b1, 16};
        vecs[4] = '{16, 8'h40, 8'h03, 1'b1, 1'b0, 4, 1'b1, 1'b0, 16};
        vecs[5] = '{1,  8'h77, 8'h00, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1};
        vecs[6] = '{7,  8'hA0, 8'h11, 1'b1, 1'b1, 2, 1'b1, 1'b0, 7};
        vecs[7] = '{16, 8'hC0, 8'h01, 1'b0, 1'b0, 4, 1'b0, 1'b0, 16};

        reset = 1'b1; start = 1'b0; in_valid = 1'b0;
        in_last = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_hold", 64'(cpu_hold), 64'd1);
        check("rst_rdy", 64'(in_ready), 64'd0);
        check("rst_we", 64'(mem_we), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(error), 64'd0);
        check("rst_cnt", 64'(byte_count), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_rdy", 64'(in_ready), 64'd0);

        for (int v = 0; v < 7; v++) begin
            img.delete();
            for (int i = 0; i < vecs[v].n; i++)
                img.push_back(vecs[v].first + 8'(i) * vecs[v].step);
            run_case($sformatf("vec%0d", v), vecs[v].n, vecs[v].last,
                     vecs[v].gappy, vecs[v].exp_w, vecs[v].exp_done,
                     vecs[v].exp_err, vecs[v].exp_cnt);
        end

        // Exactly full without last: no error until a further byte shows up.
        img.delete();
        for (int i = 0; i < vecs[7].n; i++)
            img.push_back(vecs[7].first + 8'(i));
        wr_q.delete();
        stalls = 0;
        do_start();
        drive(0, 15, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("full_writes", 64'(wr_q.size()), 64'd4);
        check("full_err", 64'(error), 64'd0);
        check("full_hold", 64'(cpu_hold), 64'd1);
        check("full_rdy", 64'(in_ready), 64'd0);
        check("full_cnt", 64'(byte_count), 64'd16);

        // Reset after two of four bytes aborts the session.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        img.delete();
        for (int i = 0; i < 4; i++) img.push_back(8'h50 + 8'(i));
        wr_q.delete();
        do_start();
        drive(0, 1, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_we", 64'(wr_q.size()), 64'd0);
        check("abort_hold", 64'(cpu_hold), 64'd1);
        check("abort_rdy", 64'(in_ready), 64'd0);
        check("abort_cnt", 64'(byte_count), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        run_case("gap4", 4, 1'b1, 1'b1, 1, 1'b1, 1'b0, 4);

        // start during LOAD is ignored; the word keeps all four bytes.
        img.delete();
        for (int i = 0; i < 4; i++) img.push_back(8'hC1 + 8'(i));
        wr_q.delete();
        stalls = 0;
        do_start();
        drive(0, 1, 1'b0, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drive(2, 3, 1'b1, 1'b0);
        verify("mid_start", 4, 1'b1, 1, 1'b1, 1'b0, 4);

        // reset wins over a simultaneous start.
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst_start_rdy", 64'(in_ready), 64'd0);
        check("rst_start_hold", 64'(cpu_hold), 64'd1);
        check("rst_start_done", 64'(done), 64'd0);

        for (int r = 0; r < 20; r++) begin
            int n = $urandom_range(1, 20);
            bit lst = (n <= CAP);
            int acc = (n > CAP) ? CAP : n;
            int nw = lst ? (acc + 3) / 4 : acc / 4;
            img.delete();
            for (int i = 0; i < n; i++) img.push_back(8'($urandom));
            run_case($sformatf("rnd%0d", r), n, lst, 1'($urandom),
                     nw, lst, !lst, acc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
